// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: peripheral address decode boundary and the
// generic pipeline-latch record used by the writeback stages.
package pipe_pkg;

  localparam int unsigned PERIPH_BASE_BIT = 8;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memtoreg;
    logic [31:0] data;
  } pipe_latch_t;

endpackage

// File: rtl/wb_result_mux.sv
// Writeback result select: ALU result, dcache word or zero-extended peripheral
// read data. Shared with the vector writeback path.
module wb_result_mux (
  input  logic [31:0] alu_result,
  input  logic [31:0] mem_read_data,
  input  logic [15:0] periph_rdata_i,
  input  logic        memtoreg,
  input  logic        periph_sel,
  output logic [31:0] result
);

  always_comb begin
    result = alu_result;
    if (memtoreg) begin
      result = periph_sel ? {16'b0, periph_rdata_i} : mem_read_data;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: stage A aligns control with synchronous dsram data and
// selects the result; stage B drives the register-file write port.
module wb_stage
  import pipe_pkg::*;
#(
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_i,
  input  logic [31:0]         alu_result_i,
  input  logic [4:0]          rd_i,
  input  logic                RegWrite_i,
  input  logic                MemToReg_i,
  input  logic [31:0]         mem_read_data,
  input  logic [15:0]         periph_rdata_i,
  input  logic                stall,
  input  logic                flush,
  output logic                rf_we,
  output logic [4:0]          rf_waddr,
  output logic [31:0]         rf_wdata,
  output logic                fwdA_valid,
  output logic [4:0]          fwdA_rd,
  output logic [31:0]         fwdA_data,
  output logic                fwdB_valid,
  output logic [4:0]          fwdB_rd,
  output logic [31:0]         fwdB_data,
  output logic [RETIRE_W-1:0] retired
);

  pipe_latch_t stage_a;
  pipe_latch_t stage_b;
  logic [31:0] a_result;
  logic        a_periph;
  logic        a_write;
  logic        unused_b;

  // Any address bit at or above the peripheral boundary selects the port.
  assign a_periph = |stage_a.data[31:PERIPH_BASE_BIT];
  assign a_write  = stage_a.valid & stage_a.regwrite & (stage_a.rd != '0);

  wb_result_mux u_result_mux (
    .alu_result     (stage_a.data),
    .mem_read_data  (mem_read_data),
    .periph_rdata_i (periph_rdata_i),
    .memtoreg       (stage_a.memtoreg),
    .periph_sel     (a_periph),
    .result         (a_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_a <= '0;
      stage_b <= '0;
      retired <= '0;
    end else if (!stall) begin
      stage_a <= '{valid: valid_i & ~flush, rd: rd_i, regwrite: RegWrite_i,
                   memtoreg: MemToReg_i, data: alu_result_i};
      // Stage B keeps the already-qualified write enable in its regwrite field.
      stage_b <= '{valid: stage_a.valid, rd: stage_a.rd, regwrite: a_write,
                   memtoreg: 1'b0, data: a_result};
      if (stage_a.valid) begin
        retired <= retired + RETIRE_W'(1);
      end
    end
  end

  assign unused_b = ^{stage_b.valid, stage_b.memtoreg};

  assign rf_we      = stage_b.regwrite;
  assign rf_waddr   = stage_b.rd;
  assign rf_wdata   = stage_b.data;

  assign fwdA_valid = a_write;
  assign fwdA_rd    = stage_a.rd;
  assign fwdA_data  = a_result;

  assign fwdB_valid = rf_we;
  assign fwdB_rd    = rf_waddr;
  assign fwdB_data  = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed literal cases plus randomized
// traffic compared every cycle against an instruction-level reference model.
module tb_wb_stage;

  localparam int unsigned RW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_i = 1'b0;
  logic [31:0]   alu_result_i = '0;
  logic [4:0]    rd_i = '0;
  logic          RegWrite_i = 1'b0;
  logic          MemToReg_i = 1'b0;
  logic [31:0]   mem_read_data;
  logic [15:0]   periph_rdata_i = '0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic          fwdA_valid;
  logic [4:0]    fwdA_rd;
  logic [31:0]   fwdA_data;
  logic          fwdB_valid;
  logic [4:0]    fwdB_rd;
  logic [31:0]   fwdB_data;
  logic [RW-1:0] retired;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  wb_stage #(.RETIRE_W(RW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_i        (valid_i),
    .alu_result_i   (alu_result_i),
    .rd_i           (rd_i),
    .RegWrite_i     (RegWrite_i),
    .MemToReg_i     (MemToReg_i),
    .mem_read_data  (mem_read_data),
    .periph_rdata_i (periph_rdata_i),
    .stall          (stall),
    .flush          (flush),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .fwdA_valid     (fwdA_valid),
    .fwdA_rd        (fwdA_rd),
    .fwdA_data      (fwdA_data),
    .fwdB_valid     (fwdB_valid),
    .fwdB_rd        (fwdB_rd),
    .fwdB_data      (fwdB_data),
    .retired        (retired)
  );

  // Synchronous dsram: address registered on the unstalled edge, data next cycle.
  logic [31:0] dmem [64];
  logic [31:0] addr_q = '0;
  always @(posedge clk) if (!stall) addr_q <= alu_result_i;
  assign mem_read_data = dmem[addr_q[7:2]];

  function automatic logic [31:0] spec_result(input bit ld, input logic [31:0] addr,
                                              input logic [15:0] per);
    if (!ld) return addr;
    if (addr[31:8] == 24'h0) return dmem[addr[7:2]];
    return {16'h0, per};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the instruction waiting for its data, and the one writing back.
  bit          ma_v = 0, ma_rw = 0, ma_ld = 0;
  logic [4:0]  ma_rd = '0;
  logic [31:0] ma_addr = '0;
  bit          mb_we = 0;
  logic [4:0]  mb_rd = '0;
  logic [31:0] mb_data = '0;
  int unsigned m_ret = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_v = 0; ma_rw = 0; ma_ld = 0; ma_rd = '0; ma_addr = '0;
      mb_we = 0; mb_rd = '0; mb_data = '0; m_ret = 0;
    end else if (!stall) begin
      mb_we   = ma_v && ma_rw && (ma_rd != 5'd0);
      mb_rd   = ma_rd;
      mb_data = spec_result(ma_ld, ma_addr, periph_rdata_i);
      if (ma_v) m_ret = (m_ret + 1) % (1 << RW);
      ma_v    = valid_i && !flush;
      ma_rw   = RegWrite_i;
      ma_ld   = MemToReg_i;
      ma_rd   = rd_i;
      ma_addr = alu_result_i;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("rf_we",      32'(rf_we),      32'(mb_we));
      chk("rf_waddr",   32'(rf_waddr),   32'(mb_rd));
      chk("rf_wdata",   rf_wdata,        mb_data);
      chk("fwdB_valid", 32'(fwdB_valid), 32'(mb_we));
      chk("fwdB_rd",    32'(fwdB_rd),    32'(mb_rd));
      chk("fwdB_data",  fwdB_data,       mb_data);
      chk("fwdA_valid", 32'(fwdA_valid), 32'(ma_v && ma_rw && (ma_rd != 5'd0)));
      chk("fwdA_rd",    32'(fwdA_rd),    32'(ma_rd));
      chk("fwdA_data",  fwdA_data,       spec_result(ma_ld, ma_addr, periph_rdata_i));
      chk("retired",    32'(retired),    m_ret);
    end
  end

  // Inputs change just after the falling edge; returns at the next falling edge.
  task automatic step(input bit v, input logic [31:0] a, input logic [4:0] r,
                      input bit rw, input bit ld, input logic [15:0] per,
                      input bit st, input bit fl);
    #1;
    valid_i = v; alu_result_i = a; rd_i = r; RegWrite_i = rw; MemToReg_i = ld;
    periph_rdata_i = per; stall = st; flush = fl;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 32'h0, 5'd0, 0, 0, periph_rdata_i, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rf_we"},      32'(rf_we),      32'h0);
    chk({tag, "_rf_waddr"},   32'(rf_waddr),   32'h0);
    chk({tag, "_rf_wdata"},   rf_wdata,        32'h0);
    chk({tag, "_fwdA_valid"}, 32'(fwdA_valid), 32'h0);
    chk({tag, "_fwdA_rd"},    32'(fwdA_rd),    32'h0);
    chk({tag, "_fwdA_data"},  fwdA_data,       32'h0);
    chk({tag, "_fwdB_valid"}, 32'(fwdB_valid), 32'h0);
    chk({tag, "_fwdB_data"},  fwdB_data,       32'h0);
    chk({tag, "_retired"},    32'(retired),    32'h0);
  endtask

  // Asynchronous reset between clock edges; returns at a falling edge.
  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    valid_i = 0; stall = 0; flush = 0; MemToReg_i = 0; RegWrite_i = 0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) dmem[i] = $urandom;
    dmem[16] = 32'hDEAD_BEEF;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    #1 rst_n = 1'b1;
    @(negedge clk);

    // ALU writeback
    step(1, 32'h1234_5678, 5'd5, 1, 0, 16'h0, 0, 0);
    chk("alu_fwdA_valid", 32'(fwdA_valid), 32'h1);
    chk("alu_fwdA_rd",    32'(fwdA_rd),    32'd5);
    chk("alu_fwdA_data",  fwdA_data,       32'h1234_5678);
    idle();
    chk("alu_rf_we",    32'(rf_we),    32'h1);
    chk("alu_rf_waddr", 32'(rf_waddr), 32'd5);
    chk("alu_rf_wdata", rf_wdata,      32'h1234_5678);
    idle();
    chk("alu_retired", 32'(retired), 32'd1);

    // Load from dcache
    step(1, 32'h0000_0040, 5'd3, 1, 1, 16'h0, 0, 0);
    chk("ld_fwdA_data", fwdA_data, 32'hDEAD_BEEF);
    idle();
    chk("ld_rf_waddr", 32'(rf_waddr), 32'd3);
    chk("ld_rf_wdata", rf_wdata,      32'hDEAD_BEEF);

    // Peripheral load
    step(1, 32'h0000_0100, 5'd4, 1, 1, 16'hA5A5, 0, 0);
    idle();
    chk("per_rf_wdata", rf_wdata, 32'h0000_A5A5);
    idle();
    chk("per_retired", 32'(retired), 32'd3);

    // Write to x0: counted but never written or forwarded
    step(1, 32'h0000_0055, 5'd0, 1, 0, 16'h0, 0, 0);
    chk("x0_fwdA_valid", 32'(fwdA_valid), 32'h0);
    idle();
    chk("x0_rf_we",      32'(rf_we),      32'h0);
    chk("x0_fwdB_valid", 32'(fwdB_valid), 32'h0);
    idle();
    chk("x0_retired", 32'(retired), 32'd4);

    // Flushed instruction: neither written nor counted
    step(1, 32'h0000_0066, 5'd9, 1, 0, 16'h0, 0, 1);
    chk("fl_fwdA_valid", 32'(fwdA_valid), 32'h0);
    idle();
    chk("fl_rf_we", 32'(rf_we), 32'h0);
    idle();
    chk("fl_retired", 32'(retired), 32'd4);

    // Stall with both stages full; flush during stall must be ignored
    step(1, 32'h0000_0077, 5'd7, 1, 0, 16'h0, 0, 0);
    step(1, 32'h0000_0088, 5'd8, 1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h0000_0099, 5'd9, 1, 0, 16'h0, 1, 1);
      chk("st_rf_we",      32'(rf_we),      32'h1);
      chk("st_rf_waddr",   32'(rf_waddr),   32'd7);
      chk("st_rf_wdata",   rf_wdata,        32'h77);
      chk("st_fwdA_valid", 32'(fwdA_valid), 32'h1);
      chk("st_fwdA_rd",    32'(fwdA_rd),    32'd8);
      chk("st_fwdA_data",  fwdA_data,       32'h88);
      chk("st_retired",    32'(retired),    32'd5);
    end
    idle();
    chk("st_rel_rf_waddr", 32'(rf_waddr), 32'd8);
    chk("st_rel_rf_wdata", rf_wdata,      32'h88);
    chk("st_rel_retired",  32'(retired),  32'd6);
    idle();
    chk("st_end_rf_we", 32'(rf_we), 32'h0);

    // Mid-operation reset, then normal latency afterwards
    step(1, 32'h0000_00AA, 5'd10, 1, 0, 16'h0, 0, 0);
    step(1, 32'h0000_00BB, 5'd11, 1, 0, 16'h0, 0, 0);
    async_reset();
    step(1, 32'h0000_00CC, 5'd12, 1, 0, 16'h0, 0, 0);
    chk("rst_fwdA_rd", 32'(fwdA_rd), 32'd12);
    idle();
    chk("rst_rf_we",    32'(rf_we),    32'h1);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd12);
    chk("rst_rf_wdata", rf_wdata,      32'hCC);
    chk("rst_retired",  32'(retired),  32'd1);

    // Randomized traffic; instruction inputs held while stalled
    begin
      bit v = 0, rw = 0, ld = 0, st = 0, fl = 0;
      logic [31:0] a = '0;
      logic [4:0] r = '0;
      for (int i = 0; i < 2000; i++) begin
        if (i == 1000) async_reset();
        st = ($urandom_range(4) == 0);
        fl = ($urandom_range(9) == 0);
        if (!st) begin
          v  = ($urandom_range(3) != 0);
          rw = ($urandom_range(3) != 0);
          ld = $urandom_range(1);
          r  = 5'($urandom_range(31));
          a  = ($urandom_range(1) == 1) ? {24'h0, 8'($urandom)} : $urandom;
        end
        step(v, a, r, rw, ld, 16'($urandom), st, fl);
      end
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
